irq_ctrl: RTL and testbench

//   Memory-mapped interrupt controller on the dMemIO bus. Latches up to NUM_SRC

---
 rtl/irq_ctrl.sv | 107 ++++++++++
 tb/tb_irq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises NUM_SRC requests onto irqOut.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic [2:0]         addr,
    input  logic [7:0]         dIn,
    input  logic               writeEn,
    input  logic               readEn,
    output logic [7:0]         dOut,
    input  logic [NUM_SRC-1:0] irqSrc,
    output logic               irqOut
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrMask    = 3'd1;
    localparam logic [2:0] AddrEdge    = 3'd2;
    localparam logic [2:0] AddrId      = 3'd3;

    logic [NUM_SRC-1:0] pendingQ, maskQ, edgeQ, srcPrevQ;
    logic [NUM_SRC-1:0] src, setVec, clrVec, pendingD, active;
    logic [7:0]         pendExt, maskExt, edgeExt, idVal, readData;
    logic               wrStrobe, rdStrobe;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1Q, sync2Q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1Q <= '0;
            sync2Q <= '0;
        end else begin
            sync1Q <= irqSrc;
            sync2Q <= sync1Q;
        end
    end

    assign src = sync2Q;
`else
    assign src = irqSrc;
`endif

    assign wrStrobe = cs & writeEn;
    assign rdStrobe = cs & readEn;

    always_comb begin
        setVec   = (edgeQ & src & ~srcPrevQ) | (~edgeQ & src);
        clrVec   = (wrStrobe && addr == AddrPending) ? dIn[NUM_SRC-1:0] : '0;
        // Set is OR-ed in after the clear so a coincident request wins.
        pendingD = (pendingQ & ~clrVec) | setVec;
        active   = pendingQ & maskQ;
    end

    // Lowest-numbered active source has priority; scan downward so it is assigned last.
    always_comb begin
        idVal = 8'hFF;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                idVal = 8'(i);
            end
        end
    end

    always_comb begin
        pendExt = '0;
        maskExt = '0;
        edgeExt = '0;
        pendExt[NUM_SRC-1:0] = pendingQ;
        maskExt[NUM_SRC-1:0] = maskQ;
        edgeExt[NUM_SRC-1:0] = edgeQ;
        case (addr)
            AddrPending: readData = pendExt;
            AddrMask:    readData = maskExt;
            AddrEdge:    readData = edgeExt;
            AddrId:      readData = idVal;
            default:     readData = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pendingQ <= '0;
            maskQ    <= '0;
            edgeQ    <= '0;
            srcPrevQ <= '0;
            irqOut   <= 1'b0;
            dOut     <= 8'h00;
        end else begin
            pendingQ <= pendingD;
            srcPrevQ <= src;
            irqOut   <= |active;
            if (wrStrobe && addr == AddrMask) begin
                maskQ <= dIn[NUM_SRC-1:0];
            end
            if (wrStrobe && addr == AddrEdge) begin
                edgeQ <= dIn[NUM_SRC-1:0];
            end
            if (rdStrobe) begin
                dOut <= readData;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; tracks IRQ_CTRL_SYNC_EN for request latency.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, cs, writeEn, readEn, irqOut;
    logic [2:0] addr;
    logic [7:0] dIn, dOut, irqSrc;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_SRC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .addr    (addr),
        .dIn     (dIn),
        .writeEn (writeEn),
        .readEn  (readEn),
        .dOut    (dOut),
        .irqSrc  (irqSrc),
        .irqOut  (irqOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (Lat) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; writeEn = 1'b1; addr = a; dIn = d;
        tick();
        cs = 1'b0; writeEn = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        cs = 1'b1; readEn = 1'b1; addr = a;
        tick();
        cs = 1'b0; readEn = 1'b0;
        chk(tag, dOut, exp);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; writeEn = 1'b0; readEn = 1'b0;
        addr = '0; dIn = '0; irqSrc = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dout", dOut, 8'h00);
        chk("rst_irq", {7'b0, irqOut}, 8'h00);

        // 1: reset values
        rd(3'd0, 8'h00, "t1_pending");
        rd(3'd1, 8'h00, "t1_mask");
        rd(3'd2, 8'h00, "t1_edge");
        rd(3'd3, 8'hFF, "t1_id");
        chk("t1_irq", {7'b0, irqOut}, 8'h00);

        // 2: edge pulse on source 2
        wr(3'd1, 8'h04);
        wr(3'd2, 8'h04);
        irqSrc = 8'h04;
        tick();
        irqSrc = 8'h00;
        settle();
        chk("t2_irq_lag", {7'b0, irqOut}, 8'h00);
        rd(3'd0, 8'h04, "t2_pending");
        chk("t2_irq_up", {7'b0, irqOut}, 8'h01);
        rd(3'd3, 8'h02, "t2_id");
        wr(3'd0, 8'h04);
        chk("t2_irq_hold", {7'b0, irqOut}, 8'h01);
        tick();
        chk("t2_irq_down", {7'b0, irqOut}, 8'h00);

        // 3: level sources 5 and 1
        wr(3'd2, 8'h00);
        wr(3'd1, 8'hFF);
        irqSrc = 8'h22;
        tick();
        settle();
        rd(3'd3, 8'h01, "t3_id1");
        wr(3'd0, 8'h02);
        rd(3'd0, 8'h22, "t3_repend");
        irqSrc = 8'h20;
        settle();
        wr(3'd0, 8'h02);
        rd(3'd3, 8'h05, "t3_id5");
        rd(3'd0, 8'h20, "t3_pending");
        irqSrc = 8'h00;
        settle();
        wr(3'd0, 8'hFF);
        rd(3'd0, 8'h00, "t3_cleared");

        // 4: masked edge request, then unmask
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h08);
        irqSrc = 8'h08;
        tick();
        irqSrc = 8'h00;
        settle();
        rd(3'd0, 8'h08, "t4_pending");
        rd(3'd3, 8'hFF, "t4_id");
        chk("t4_irq_masked", {7'b0, irqOut}, 8'h00);
        wr(3'd1, 8'h08);
        tick();
        chk("t4_irq_unmask", {7'b0, irqOut}, 8'h01);

        // 5: set beats clear in the same cycle, then reset from all-pending
        wr(3'd2, 8'h01);
        irqSrc = 8'h01;
        settle();
        wr(3'd0, 8'h01);
        irqSrc = 8'h00;
        rd(3'd0, 8'h09, "t5_set_wins");
        wr(3'd2, 8'h00);
        irqSrc = 8'hFF;
        tick();
        settle();
        rd(3'd0, 8'hFF, "t5_all");
        rst = 1'b1;
        irqSrc = 8'h00;
        tick();
        rst = 1'b0;
        chk("t5_rst_irq", {7'b0, irqOut}, 8'h00);
        chk("t5_rst_dout", dOut, 8'h00);
        rd(3'd0, 8'h00, "t5_rst_pending");
        rd(3'd1, 8'h00, "t5_rst_mask");
        rd(3'd2, 8'h00, "t5_rst_edge");

        // 6: unmapped offsets, cs=0 strobes, read-during-write
        wr(3'd1, 8'h3C);
        for (int a = 4; a < 8; a++) begin
            wr(3'(a), 8'hAA);
            rd(3'(a), 8'h00, "t6_unmapped");
        end
        rd(3'd1, 8'h3C, "t6_mask_kept");
        cs = 1'b0; writeEn = 1'b1; readEn = 1'b1; addr = 3'd1; dIn = 8'hFF;
        tick();
        writeEn = 1'b0; readEn = 1'b0;
        chk("t6_cs0_hold", dOut, 8'h3C);
        rd(3'd1, 8'h3C, "t6_cs0_nowrite");
        cs = 1'b1; writeEn = 1'b1; readEn = 1'b1; addr = 3'd1; dIn = 8'h55;
        tick();
        cs = 1'b0; writeEn = 1'b0; readEn = 1'b0;
        chk("t6_rdwr_old", dOut, 8'h3C);
        rd(3'd1, 8'h55, "t6_rdwr_new");
        rd(3'd0, 8'h00, "t6_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
